// File: rtl/game_pkg.sv
// Types and constants shared by the mode selector, round timer and display path.
package game_pkg;
    localparam int TIME_W       = 8;
    localparam int DEF_TICK_DIV = 50_000_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;
endpackage

// File: rtl/round_timer_tick_prescaler.sv
// tick_prescaler: one-cycle tick every TICK_DIV enabled cycles, count held while en is low.
// tick is decoded from the count register; clr restarts the count from zero.
module tick_prescaler
    import game_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = en && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/round_timer.sv
// round_timer: counts `limit` prescaled ticks down with pause, hit-stop and a timeout pulse; all outputs registered.
// Defining ROUND_TIMER_WARN_EN adds the registered `warn` output (remain in 1..WARN_LVL during a round).
module round_timer
    import game_pkg::*;
#(
    parameter int                TICK_DIV = DEF_TICK_DIV,
    parameter logic [TIME_W-1:0] WARN_LVL = 8'd5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TIME_W-1:0] limit,
    input  logic              start,
    input  logic              pause,
    input  logic              hit,
    output logic [TIME_W-1:0] remain,
    output logic              busy,
    output logic              timeout,
    output logic              stopped
`ifdef ROUND_TIMER_WARN_EN
    ,
    output logic              warn
`endif
);
    timer_state_t      r_state;
    logic [TIME_W-1:0] r_remain;
    logic              r_busy;
    logic              r_timeout;
    logic              r_stopped;
    logic              w_tick;
    logic              w_in_round;

    assign w_in_round = (r_state == RUN) || (r_state == PAUSE);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (r_state == RUN),
        .clr  (start),
        .tick (w_tick)
    );

`ifdef ROUND_TIMER_WARN_EN
    logic r_warn;
    assign warn = r_warn;
`endif

    // Priority: start > hit > tick > pause. A pause landing on a tick is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_remain  <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_stopped <= 1'b0;
`ifdef ROUND_TIMER_WARN_EN
            r_warn    <= 1'b0;
`endif
        end else begin
            r_timeout <= 1'b0;
            r_stopped <= 1'b0;
            if (start) begin
                r_remain <= limit;
                if (limit == '0) begin
                    r_state   <= EXPIRED;
                    r_busy    <= 1'b0;
                    r_timeout <= 1'b1;
                end else begin
                    r_state <= RUN;
                    r_busy  <= 1'b1;
                end
`ifdef ROUND_TIMER_WARN_EN
                r_warn <= (limit != '0) && (limit <= WARN_LVL);
`endif
            end else if (hit && w_in_round) begin
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_stopped <= 1'b1;
`ifdef ROUND_TIMER_WARN_EN
                r_warn    <= 1'b0;
`endif
            end else if (w_tick) begin
                if (r_remain > 8'd1) begin
                    r_remain <= r_remain - 8'd1;
`ifdef ROUND_TIMER_WARN_EN
                    r_warn   <= (r_remain - 8'd1) <= WARN_LVL;
`endif
                end else begin
                    r_remain  <= '0;
                    r_state   <= EXPIRED;
                    r_busy    <= 1'b0;
                    r_timeout <= 1'b1;
`ifdef ROUND_TIMER_WARN_EN
                    r_warn    <= 1'b0;
`endif
                end
            end else if (pause) begin
                if (r_state == RUN) begin
                    r_state <= PAUSE;
                end else if (r_state == PAUSE) begin
                    r_state <= RUN;
                end
            end
        end
    end

    assign remain  = r_remain;
    assign busy    = r_busy;
    assign timeout = r_timeout;
    assign stopped = r_stopped;
endmodule
